// File: rtl/truth_checker_pkg.sv
// Shared types and constants for the truth-table response checker.
package truth_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned MISR_W    = 8;
  // x^8 + x^6 + x^5 + x^4 + 1, x^8 term implied by the shift-out bit
  localparam logic [MISR_W-1:0] MISR_POLY = 8'h71;
  localparam logic [MISR_W-1:0] MISR_SEED = 8'hFF;

  // 3-input majority: Y=1 for in_vec 3, 5, 6, 7
  localparam logic [7:0] EXP_MAJ3 = 8'b1110_1000;

endpackage

// File: rtl/tt_misr.sv
// 8-bit multiple-input signature register; seed loaded on clear, data folded in on en.
module tt_misr
  import truth_checker_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [MISR_W-1:0] data,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_next;

  always_comb begin
    w_next = {r_sig[MISR_W-2:0], 1'b0} ^ (r_sig[MISR_W-1] ? MISR_POLY : '0) ^ data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clear) begin
      r_sig <= MISR_SEED;
    end else if (en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/truth_table_checker.sv
// Checks (in_vec, dut_y) pairs against EXP_TABLE, tracks coverage, errors and first failure.
// Optional signature MISR enabled by defining TT_CHECKER_MISR_EN.
module truth_table_checker
  import truth_checker_pkg::*;
#(
  parameter int unsigned                N_IN      = 3,
  parameter logic [(2**N_IN)-1:0]       EXP_TABLE = EXP_MAJ3,
  parameter int unsigned                TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [N_IN-1:0]       in_vec,
  input  logic                  dut_y,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [N_IN:0]         err_count,
  output logic [(2**N_IN)-1:0]  seen_mask,
  output logic                  fail_valid,
  output logic [N_IN-1:0]       fail_vec,
  output logic [7:0]            signature
);

  localparam int unsigned NV = 2**N_IN;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t          r_state;
  logic [N_IN:0]   r_err_count;
  logic [NV-1:0]   r_seen_mask;
  logic            r_fail_valid;
  logic [N_IN-1:0] r_fail_vec;
  logic            r_timeout;
  logic [CW-1:0]   r_idle_cnt;

  logic            w_run;
  logic            w_accept;
  logic            w_clear;
  logic            w_mismatch;
  logic [NV-1:0]   w_seen_next;
  logic [CW-1:0]   w_idle_inc;
  logic            w_idle_expire;

  always_comb begin
    w_run         = (r_state == ST_RUN);
    w_accept      = w_run & in_valid;
    w_clear       = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    w_mismatch    = (dut_y != EXP_TABLE[in_vec]);
    w_seen_next   = r_seen_mask | (NV'(1) << in_vec);
    w_idle_inc    = r_idle_cnt + CW'(1);
    w_idle_expire = (TIMEOUT != 0) && (w_idle_inc == CW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_err_count  <= '0;
      r_seen_mask  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
      r_timeout    <= 1'b0;
      r_idle_cnt   <= '0;
    end else if (w_clear) begin
      r_state      <= ST_RUN;
      r_err_count  <= '0;
      r_seen_mask  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
      r_timeout    <= 1'b0;
      r_idle_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            // an accept always beats an expiring idle counter
            r_idle_cnt  <= '0;
            r_seen_mask <= w_seen_next;
            if (w_mismatch) begin
              if (r_err_count != '1) begin
                r_err_count <= r_err_count + 1'b1;
              end
              if (!r_fail_valid) begin
                r_fail_valid <= 1'b1;
                r_fail_vec   <= in_vec;
              end
            end
            if (&w_seen_next) begin
              r_state <= ST_DONE;
            end
          end else begin
            r_idle_cnt <= w_idle_inc;
            if (w_idle_expire) begin
              r_timeout <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_IDLE, ST_DONE: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = w_run;
  assign busy       = w_run;
  assign done       = (r_state == ST_DONE);
  assign pass       = done & ~r_timeout & (r_err_count == '0);
  assign timeout    = r_timeout;
  assign err_count  = r_err_count;
  assign seen_mask  = r_seen_mask;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

`ifdef TT_CHECKER_MISR_EN
  logic [MISR_W-1:0] w_misr_data;
  logic [MISR_W-1:0] w_sig;

  assign w_misr_data = MISR_W'({in_vec, dut_y});

  tt_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .en    (w_accept),
    .data  (w_misr_data),
    .sig   (w_sig)
  );

  assign signature = w_sig;
`else
  assign signature = '0;
`endif

endmodule
